// File: rtl/bist_ctrl.sv
// Logic-BIST sequencer: runs the pattern LFSR for a programmed number of cycles,
// compacts CUT responses into a MISR and checks the signature against a golden value.
// Optional abort input is enabled by defining BIST_CTRL_ABORT_EN.
module bist_ctrl #(
  parameter int                RESP_W    = 16,
  parameter logic [RESP_W-1:0] MISR_TAPS = 16'hB400,
  parameter int                PIPE_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              start,
  input  logic [18:0]       n_patterns,
  input  logic [RESP_W-1:0] resp,
  input  logic [RESP_W-1:0] golden,
`ifdef BIST_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              lfsr_bist_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [18:0] FLUSH_LEN = 19'(PIPE_LAT);

  state_t            state_q, state_d;
  logic [18:0]       cnt_q, cnt_d;
  logic [RESP_W-1:0] sig_q, sig_d;
  logic              pass_q, pass_d;
  logic [RESP_W-1:0] misr_next;

  // Shift left, feed the tap parity into bit 0, fold in the response; the top bit drops off.
  assign misr_next = {sig_q[RESP_W-2:0], ^(sig_q & MISR_TAPS)} ^ resp;

  // NOTE: every variable gets its hold value before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SEED;
          cnt_d   = n_patterns;
          sig_d   = '0;
          pass_d  = 1'b0;
        end
      end

      S_SEED: begin
        if (cnt_q == '0) begin
          state_d = (PIPE_LAT == 0) ? S_COMPARE : S_FLUSH;
          cnt_d   = FLUSH_LEN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sig_d = misr_next;
        cnt_d = cnt_q - 19'd1;
        if (cnt_q == 19'd1) begin
          state_d = (PIPE_LAT == 0) ? S_COMPARE : S_FLUSH;
          cnt_d   = FLUSH_LEN;
        end
      end

      // The counter is reused to time the pipeline drain.
      S_FLUSH: begin
        sig_d = misr_next;
        cnt_d = cnt_q - 19'd1;
        if (cnt_q == 19'd1) state_d = S_COMPARE;
      end

      S_COMPARE: begin
        pass_d  = (sig_q == golden);
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

`ifdef BIST_CTRL_ABORT_EN
    // Abort wins over start; the signature is left intact for debug.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sig_d   = sig_q;
      pass_d  = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sig_q        <= '0;
      pass_q       <= 1'b0;
      lfsr_bist_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sig_q        <= sig_d;
      pass_q       <= pass_d;
      lfsr_bist_en <= (state_d == S_SEED) || (state_d == S_RUN);
      busy         <= (state_d == S_SEED) || (state_d == S_RUN) ||
                      (state_d == S_FLUSH) || (state_d == S_COMPARE);
      done         <= (state_d == S_DONE);
    end
  end

  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed self-checking bench for bist_ctrl; three instances cover PIPE_LAT = 0, 1, 2
// driven from shared stimulus, each step checked against hand-computed values.
module tb_bist_ctrl;

  logic        clk;
  logic        rst_l;
  logic        start;
  logic [18:0] n_patterns;
  logic [15:0] resp;
  logic [15:0] golden;
  logic        abort;

  logic [2:0]  en, busy, done, pass;
  logic [15:0] sig [3];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bist_ctrl #(.RESP_W(16), .MISR_TAPS(16'hB400), .PIPE_LAT(0)) u0 (
    .clk(clk), .rst_l(rst_l), .start(start), .n_patterns(n_patterns),
    .resp(resp), .golden(golden),
`ifdef BIST_CTRL_ABORT_EN
    .abort(abort),
`endif
    .lfsr_bist_en(en[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .signature(sig[0])
  );

  bist_ctrl #(.RESP_W(16), .MISR_TAPS(16'hB400), .PIPE_LAT(1)) u1 (
    .clk(clk), .rst_l(rst_l), .start(start), .n_patterns(n_patterns),
    .resp(resp), .golden(golden),
`ifdef BIST_CTRL_ABORT_EN
    .abort(abort),
`endif
    .lfsr_bist_en(en[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .signature(sig[1])
  );

  bist_ctrl #(.RESP_W(16), .MISR_TAPS(16'hB400), .PIPE_LAT(2)) u2 (
    .clk(clk), .rst_l(rst_l), .start(start), .n_patterns(n_patterns),
    .resp(resp), .golden(golden),
`ifdef BIST_CTRL_ABORT_EN
    .abort(abort),
`endif
    .lfsr_bist_en(en[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .signature(sig[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    tick();
  endtask

  // Pulses start so that the returned-to point is just after edge E0.
  task automatic launch(input logic [18:0] n);
    n_patterns = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Checks the control outputs of instance k in one go.
  task automatic ctl(input string tag, input int k, input logic e, input logic b, input logic d);
    check({tag, ".en"},   32'(en[k]),   32'(e));
    check({tag, ".busy"}, 32'(busy[k]), 32'(b));
    check({tag, ".done"}, 32'(done[k]), 32'(d));
  endtask

  initial begin
    rst_l = 1'b0; start = 1'b0; n_patterns = '0; resp = '0; golden = '0; abort = 1'b0;
    #2;
    ctl("rst", 1, 1'b0, 1'b0, 1'b0);
    check("rst.pass", 32'(pass[1]), 32'h0);
    check("rst.sig",  32'(sig[1]),  32'h0);
    tick();
    rst_l = 1'b1;
    tick();
    ctl("idle", 1, 1'b0, 1'b0, 1'b0);

    // All-zero response, N=4, PIPE_LAT=1: bist_en after E0..E4, done after E7.
    golden = 16'h0000; resp = 16'h0000;
    launch(19'd4);
    ctl("t1.e0", 1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      ctl($sformatf("t1.e%0d", i), 1, 1'b1, 1'b1, 1'b0);
    end
    tick(); ctl("t1.e5", 1, 1'b0, 1'b1, 1'b0);
    tick(); ctl("t1.e6", 1, 1'b0, 1'b1, 1'b0);
    tick(); ctl("t1.e7", 1, 1'b0, 1'b0, 1'b1);
    check("t1.pass", 32'(pass[1]), 32'h1);
    check("t1.sig",  32'(sig[1]),  32'h0);
    tick(); ctl("t1.hold", 1, 1'b0, 1'b0, 1'b1);

    // Single-hot response, PIPE_LAT=0, N=3: 0001 -> 0002 -> 0004, done after E5.
    do_reset();
    golden = 16'h0004;
    launch(19'd3);
    check("t2.sig.e0", 32'(sig[0]), 32'h0);
    tick(); resp = 16'h0001;
    tick(); resp = 16'h0000;
    check("t2.sig.e2", 32'(sig[0]), 32'h0001);
    tick(); check("t2.sig.e3", 32'(sig[0]), 32'h0002);
    tick(); check("t2.sig.e4", 32'(sig[0]), 32'h0004);
    ctl("t2.e4", 0, 1'b0, 1'b1, 1'b0);
    tick(); ctl("t2.e5", 0, 1'b0, 1'b0, 1'b1);
    check("t2.pass", 32'(pass[0]), 32'h1);

    // Restart from DONE with a wrong golden value.
    golden = 16'h0005;
    launch(19'd3);
    ctl("t2b.e0", 0, 1'b1, 1'b1, 1'b0);
    check("t2b.sig.clr", 32'(sig[0]), 32'h0);
    tick(); resp = 16'h0001;
    tick(); resp = 16'h0000;
    tick(); tick(); tick();
    ctl("t2b.e5", 0, 1'b0, 1'b0, 1'b1);
    check("t2b.sig",  32'(sig[0]),  32'h0004);
    check("t2b.pass", 32'(pass[0]), 32'h0);

    // Top bit is dropped and fed back through tap 15: 8000 -> 0001.
    do_reset();
    golden = 16'h0001;
    launch(19'd2);
    tick(); resp = 16'h8000;
    tick(); resp = 16'h0000;
    check("t3.sig.e2", 32'(sig[0]), 32'h8000);
    tick(); check("t3.sig.e3", 32'(sig[0]), 32'h0001);
    tick(); ctl("t3.e4", 0, 1'b0, 1'b0, 1'b1);
    check("t3.pass", 32'(pass[0]), 32'h1);

    // Second start and n_patterns change during RUN are ignored.
    do_reset();
    golden = 16'h0000; resp = 16'h0000;
    launch(19'd4);
    tick(); tick();
    start = 1'b1; n_patterns = 19'd50;
    tick();
    start = 1'b0;
    ctl("t4.e3", 1, 1'b1, 1'b1, 1'b0);
    tick();
    tick(); ctl("t4.e5", 1, 1'b0, 1'b1, 1'b0);
    tick(); ctl("t4.e6", 1, 1'b0, 1'b1, 1'b0);
    tick(); ctl("t4.e7", 1, 1'b0, 1'b0, 1'b1);
    check("t4.pass", 32'(pass[1]), 32'h1);

    // Asynchronous reset two cycles into RUN clears everything at once.
    do_reset();
    resp = 16'hA5A5;
    launch(19'd100);
    tick(); tick(); tick();
    check("t5.sig.nz", 32'(sig[1] != 16'h0), 32'h1);
    rst_l = 1'b0;
    #1;
    ctl("t5.rst", 1, 1'b0, 1'b0, 1'b0);
    check("t5.sig",  32'(sig[1]),  32'h0);
    check("t5.pass", 32'(pass[1]), 32'h0);
    tick();
    rst_l = 1'b1;
    tick(); tick();
    ctl("t5.idle", 1, 1'b0, 1'b0, 1'b0);
    resp = 16'h0000;

    // N=0, PIPE_LAT=2: one SEED cycle, two flush compactions (0003 then 0006^0010).
    golden = 16'h0016;
    launch(19'd0);
    ctl("t6.e0", 2, 1'b1, 1'b1, 1'b0);
    tick(); resp = 16'h0003;
    ctl("t6.e1", 2, 1'b0, 1'b1, 1'b0);
    tick(); resp = 16'h0010;
    check("t6.sig.e2", 32'(sig[2]), 32'h0003);
    tick(); resp = 16'h0000;
    check("t6.sig.e3", 32'(sig[2]), 32'h0016);
    ctl("t6.e3", 2, 1'b0, 1'b1, 1'b0);
    tick(); ctl("t6.e4", 2, 1'b0, 1'b0, 1'b1);
    check("t6.pass", 32'(pass[2]), 32'h1);
    launch(19'd0);
    ctl("t6r.e0", 2, 1'b1, 1'b1, 1'b0);
    check("t6r.sig", 32'(sig[2]), 32'h0);

`ifdef BIST_CTRL_ABORT_EN
    // Abort during FLUSH returns to IDLE with the signature held.
    do_reset();
    resp = 16'h0007;
    launch(19'd1);
    tick(); tick();
    check("t7.sig.e2", 32'(sig[2]), 32'h0007);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ctl("t7.abort", 2, 1'b0, 1'b0, 1'b0);
    check("t7.pass", 32'(pass[2]), 32'h0);
    check("t7.sig",  32'(sig[2]),  32'h0007);
    tick(); ctl("t7.idle", 2, 1'b0, 1'b0, 1'b0);

    // Abort beats start in DONE.
    resp = 16'h0000; golden = 16'h0000;
    launch(19'd0);
    tick(); tick(); tick(); tick();
    ctl("t8.done", 2, 1'b0, 1'b0, 1'b1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    ctl("t8.abort", 2, 1'b0, 1'b0, 1'b0);
    check("t8.pass", 32'(pass[2]), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

Sequencing controller for the 247-bit pattern LFSR (`lfsr247`) used in logic BIST. On a start pulse it drives the LFSR's `bist_en` for a programmed number of pattern cycles and compacts the circuit-under-test response into a multiple-input signature register (MISR). It then flushes the CUT pipeline, compares the signature against a golden value, and reports done/pass. It sits between the test-access logic (start, golden, pattern count) and the LFSR/CUT/response path.

## Interface
- `RESP_W`, 16: response and signature width; minimum 2.
- `MISR_TAPS`, 16'hB400: feedback mask, RESP_W bits wide.
- `PIPE_LAT`, 1: CUT response latency in cycles, 0..15; sets FLUSH length.
- `clk`  in  1  clock; all state on rising edge.
- `rst_l`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a test.
- `n_patterns`  in  19  pattern cycle count; sampled on an accepted start.
- `resp`  in  RESP_W  CUT response word; compacted every RUN/FLUSH cycle.
- `golden`  in  RESP_W  expected signature; sampled in COMPARE.
- `abort`  in  1  only when `BIST_CTRL_ABORT_EN` is defined.
- `lfsr_bist_en`  out  1  drives LFSR `bist_en`.
- `busy`  out  1  high in SEED, RUN, FLUSH and COMPARE.
- `done`  out  1  high in DONE.
- `pass`  out  1  compare result; valid while `done` is high.
- `signature`  out  RESP_W  current MISR contents.

## Operation
- States: IDLE, SEED, RUN, FLUSH, COMPARE, DONE.
- IDLE: start=1 → SEED. Latch n_patterns into a 19-bit down-counter. Clear MISR to 0.
- SEED: one cycle with lfsr_bist_en=1, so the LFSR loads its seed. No compaction. If count==0 → FLUSH, or → COMPARE when PIPE_LAT=0. Otherwise → RUN.
- RUN: lfsr_bist_en=1. MISR compacts each cycle and the counter decrements. Leave RUN on the cycle the counter reaches 1: → FLUSH, or → COMPARE when PIPE_LAT=0.
- FLUSH: lfsr_bist_en=0. MISR keeps compacting for exactly PIPE_LAT cycles, then → COMPARE.
- COMPARE: no compaction. Register pass <= (signature == golden), then → DONE.
- DONE: done=1; pass and signature are held. start=1 → SEED, which restarts the test with the MISR cleared. Otherwise stay in DONE.
- MISR update: `sig_next = {sig[RESP_W-2:0], ^(sig & MISR_TAPS)} ^ resp`. Width stays RESP_W; the bit shifted out of the top is dropped.
- start is ignored while busy. n_patterns changes after acceptance have no effect.
- Counter is 19 bits, so the maximum is 524287 patterns with no wrap.

## Timing
- Reset (rst_l=0, asynchronous): state=IDLE, lfsr_bist_en=0, busy=0, done=0, pass=0, signature=0, counter=0.
- Rising edge E0 samples start. From E0:
  - lfsr_bist_en=1 and busy=1 after E0.
  - lfsr_bist_en falls after edge E0+1+N.
  - done rises after edge E0+N+PIPE_LAT+2, with pass valid in the same cycle.
- Number of compacted responses is always N+PIPE_LAT.
- When N=0 there is one SEED cycle with bist_en high, followed only by FLUSH.
- All outputs are registered; no combinational path from inputs to outputs.
- rst_l asserted mid-test returns everything to the reset values immediately. The test must be restarted with a new start.

## Configuration
- `BIST_CTRL_ABORT_EN` defined:
  - Adds an `abort` input.
  - abort=1 in any state other than IDLE → IDLE on the next edge, with lfsr_bist_en=0, busy=0, done=0 and pass=0.
  - The signature is retained for debug.
  - abort has priority over start.
- Not defined: the port is absent, and only rst_l terminates a test.

## Test plan
- All-zero response, N=4, PIPE_LAT=1, golden=16'h0000, start at edge 0 → lfsr_bist_en high after edges 0..4; done=1 and pass=1 after edge 7; signature=16'h0000.
- Single-hot response, PIPE_LAT=0, N=3, resp=16'h0001 in the first RUN cycle then 0, golden=16'h0004 → signature 0001→0002→0004; done after edge 5; pass=1. Repeat with golden=16'h0005 → pass=0.
- start pulsed again in RUN, and n_patterns changed mid-run → no restart; done timing unchanged from the first start.
- rst_l driven low two cycles into RUN, N=100 → all outputs 0 immediately. After release, state is IDLE with busy=0 until a new start.
- N=0, PIPE_LAT=2 → one SEED cycle with bist_en high; done after edge 4; two responses compacted. Then start in DONE → full restart with signature cleared to 0.
- With `BIST_CTRL_ABORT_EN`: abort during FLUSH → IDLE next edge; busy=0, done=0, pass=0, signature held. abort and start in the same cycle in DONE → IDLE.
